// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Contents:
//   fetch_state_t     - states of the instruction fetch FSM
//   DEF_ADDR_W        - default PC / instruction address width
//   DEF_DATA_W        - default instruction word width
//   INSTR_ALIGN_MASK  - address bits that must be zero for a legal fetch
//   is_misaligned()   - alignment test applied to the low address bits
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DELIV,
        ADV,
        ERR
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for an outstanding instruction-memory request.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, clears the count
//   clr     - clears the count (held while no request is outstanding)
//   en      - counts one wait cycle
//   expired - count has reached TIMEOUT-1, i.e. this is the last wait cycle
// The count saturates at TIMEOUT so it can never wrap back into range.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != TW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage sitting between the PC register and decode.
// Samples the PC, requests the word from instruction memory over a req/ack
// handshake, holds it in IR until decode accepts it, then pulses PCWre for
// one cycle so the PC advances only after the instruction was consumed.
// Ports:
//   CLK, Reset         - clock and synchronous active-high reset
//   Address            - current PC value
//   Halt               - suppresses new fetches (looked at in IDLE only)
//   IM_Req, IM_Addr    - memory request and its address (held while pending)
//   IM_Ack, IM_RData   - memory response strobe and instruction word
//   IR, IR_Valid       - instruction register and its undelivered flag
//   Stall              - decode back-pressure while IR is presented
//   PCWre              - one-cycle PC write enable
//   FetchErr           - sticky misalignment / timeout error
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Halt,
    output logic              IM_Req,
    output logic [ADDR_W-1:0] IM_Addr,
    input  logic              IM_Ack,
    input  logic [DATA_W-1:0] IM_RData,
    output logic [DATA_W-1:0] IR,
    output logic              IR_Valid,
    input  logic              Stall,
    output logic              PCWre,
    output logic              FetchErr
);

    fetch_state_t state;
    logic         expired;

    // The timer only runs while a request is outstanding and idles at zero
    // otherwise, so every REQ visit starts counting from zero.
    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .rst    (Reset),
        .clr    (state != REQ),
        .en     ((state == REQ) && !IM_Ack),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            IM_Req   <= 1'b0;
            IM_Addr  <= '0;
            IR       <= '0;
            IR_Valid <= 1'b0;
            PCWre    <= 1'b0;
            FetchErr <= 1'b0;
        end else begin
            case (state)
                // Any IM_Ack seen here is stale and deliberately ignored.
                IDLE: begin
                    if (!Halt) begin
                        if (is_misaligned(Address[1:0])) begin
                            FetchErr <= 1'b1;
                            state    <= ERR;
                        end else begin
                            IM_Addr <= Address;
                            IM_Req  <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end

                // Ack takes priority over a timeout in the same cycle.
                REQ: begin
                    if (IM_Ack) begin
                        IR       <= IM_RData;
                        IR_Valid <= 1'b1;
                        IM_Req   <= 1'b0;
                        state    <= DELIV;
                    end else if (expired) begin
                        IM_Req   <= 1'b0;
                        FetchErr <= 1'b1;
                        state    <= ERR;
                    end
                end

                // IR keeps its value after delivery; only the flag drops.
                DELIV: begin
                    if (!Stall) begin
                        IR_Valid <= 1'b0;
                        PCWre    <= 1'b1;
                        state    <= ADV;
                    end
                end

                // PC updates on the edge closing this cycle, so IDLE next
                // cycle already sees the advanced Address.
                ADV: begin
                    PCWre <= 1'b0;
                    state <= IDLE;
                end

                ERR: begin
                    IM_Req   <= 1'b0;
                    IR_Valid <= 1'b0;
                    PCWre    <= 1'b0;
                    FetchErr <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Stimulus pushes the expected output
// events into a queue; a monitor derives events from the DUT outputs on the
// falling edge and checks them in order against that queue.
module tb_instr_fetch_unit;

    localparam int EV_REQ    = 0;  // IM_Req rise, value = IM_Addr
    localparam int EV_REQLEN = 1;  // IM_Req fall, value = cycles high
    localparam int EV_IR     = 2;  // IR_Valid rise, value = IR
    localparam int EV_IRLEN  = 3;  // IR_Valid fall, value = cycles (FFFF if IR moved)
    localparam int EV_PCW    = 4;  // PCWre fall, value = cycles high
    localparam int EV_ERR    = 5;  // FetchErr rise

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic        Halt;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Ack;
    logic [31:0] IM_RData;
    logic [31:0] IR;
    logic        IR_Valid;
    logic        Stall;
    logic        PCWre;
    logic        FetchErr;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // PC register model and memory responder controls
    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] pc_val;
    logic        mem_en;
    int          mem_lat;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic        stray_ack;
    int          mem_cnt;

    assign Address  = pc;
    assign IM_Ack   = mem_ack | stray_ack;
    assign IM_RData = mem_data;

    instr_fetch_unit #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Address (Address),
        .Halt    (Halt),
        .IM_Req  (IM_Req),
        .IM_Addr (IM_Addr),
        .IM_Ack  (IM_Ack),
        .IM_RData(IM_RData),
        .IR      (IR),
        .IR_Valid(IR_Valid),
        .Stall   (Stall),
        .PCWre   (PCWre),
        .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pc_load) pc <= pc_val;
        else if (PCWre) pc <= pc + 32'd4;
    end

    // Acks mem_lat cycles after the request was first seen.
    always begin
        @(posedge CLK);
        #1;
        if (IM_Req && mem_en) begin
            mem_ack = (mem_cnt == mem_lat);
            mem_cnt++;
        end else begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    function automatic string kname(input int k);
        case (k)
            EV_REQ:    return "req";
            EV_REQLEN: return "req_len";
            EV_IR:     return "ir";
            EV_IRLEN:  return "ir_valid_len";
            EV_PCW:    return "pcwre_len";
            default:   return "fetch_err";
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ev(input int kind, input logic [31:0] val);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_%s: got %h while no event was expected", kname(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL event_%s: got %s=%h expected %s=%h",
                         kname(kind), kname(kind), val, kname(e.kind), e.val);
            end
        end
    endtask

    // Monitor
    logic        req_q = 1'b0, irv_q = 1'b0, pcw_q = 1'b0, err_q = 1'b0;
    int          req_len, irv_len, pcw_len;
    logic [31:0] ir_first;
    logic        ir_stable;

    always @(negedge CLK) begin
        if (IM_Req) begin
            if (!req_q) begin
                ev(EV_REQ, IM_Addr);
                req_len = 1;
            end else req_len++;
        end else if (req_q) ev(EV_REQLEN, 32'(req_len));

        if (IR_Valid) begin
            if (!irv_q) begin
                ev(EV_IR, IR);
                ir_first  = IR;
                ir_stable = 1'b1;
                irv_len   = 1;
            end else begin
                irv_len++;
                if (IR !== ir_first) ir_stable = 1'b0;
            end
        end else if (irv_q) ev(EV_IRLEN, ir_stable ? 32'(irv_len) : 32'hFFFF);

        if (PCWre) begin
            if (!pcw_q) pcw_len = 1;
            else pcw_len++;
        end else if (pcw_q) ev(EV_PCW, 32'(pcw_len));

        if (FetchErr && !err_q) ev(EV_ERR, 32'd0);

        req_q = IM_Req;
        irv_q = IR_Valid;
        pcw_q = PCWre;
        err_q = FetchErr;
    end

    task automatic wait_level(input int sel, input logic lvl, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (((sel == 0) ? IM_Req : IR_Valid) == lvl) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s: got no edge within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
        chk({"drain_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_im_req"},   {31'd0, IM_Req},   32'd0);
        chk({tag, "_im_addr"},  IM_Addr,           32'd0);
        chk({tag, "_ir"},       IR,                32'd0);
        chk({tag, "_ir_valid"}, {31'd0, IR_Valid}, 32'd0);
        chk({tag, "_pcwre"},    {31'd0, PCWre},    32'd0);
        chk({tag, "_fetcherr"}, {31'd0, FetchErr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Halt = 1'b1; Stall = 1'b0;
        pc_load = 1'b1; pc_val = 32'd0;
        mem_en = 1'b1; mem_lat = 0; mem_data = 32'h2001_0004;
        mem_ack = 1'b0; stray_ack = 1'b0; mem_cnt = 0;
        repeat (2) @(negedge CLK);
        chk_zero_outputs("reset");
        Reset = 1'b0; pc_load = 1'b0;
        @(negedge CLK);

        // Zero-latency fetch, then a second fetch at PC+4 with Halt raised in REQ
        push(EV_REQ, 32'd0);  push(EV_REQLEN, 32'd1);
        push(EV_IR, 32'h2001_0004); push(EV_IRLEN, 32'd1); push(EV_PCW, 32'd1);
        push(EV_REQ, 32'd4);  push(EV_REQLEN, 32'd1);
        push(EV_IR, 32'h2001_0004); push(EV_IRLEN, 32'd1); push(EV_PCW, 32'd1);
        Halt = 1'b0;
        wait_level(0, 1'b1, 20, "req0");
        wait_level(0, 1'b0, 20, "req0_drop");
        wait_level(0, 1'b1, 20, "req4");
        Halt = 1'b1;
        wait_drain(20, "fetch0");
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("halt_idle_req", {31'd0, IM_Req}, 32'd0);
        end

        // 3-cycle ack latency (ack on the last timer cycle) plus 2 stall cycles
        mem_lat = 3; mem_data = 32'h8C41_0008; Stall = 1'b1;
        push(EV_REQ, 32'd8); push(EV_REQLEN, 32'd4);
        push(EV_IR, 32'h8C41_0008); push(EV_IRLEN, 32'd3); push(EV_PCW, 32'd1);
        Halt = 1'b0;
        wait_level(0, 1'b1, 20, "req8");
        Halt = 1'b1;
        wait_level(1, 1'b1, 20, "deliv8");
        repeat (2) @(negedge CLK);
        Stall = 1'b0;
        wait_drain(20, "fetch8");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_fetch_idle_req", {31'd0, IM_Req}, 32'd0);
        end
        chk("ir_retained", IR, 32'h8C41_0008);

        // Reset in the second REQ cycle, then a stray ack in IDLE
        push(EV_REQ, 32'd12); push(EV_REQLEN, 32'd2);
        Halt = 1'b0;
        wait_level(0, 1'b1, 20, "req12");
        Halt = 1'b1;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        chk_zero_outputs("midreq_reset");
        Reset = 1'b0;
        @(negedge CLK);
        mem_data = 32'hBAD0_BAD0; stray_ack = 1'b1;
        @(negedge CLK);
        stray_ack = 1'b0;
        chk("stray_ir", IR, 32'd0);
        chk("stray_ir_valid", {31'd0, IR_Valid}, 32'd0);
        chk("stray_im_req", {31'd0, IM_Req}, 32'd0);
        wait_drain(5, "reset_req");

        mem_lat = 1; mem_data = 32'h0062_2020;
        push(EV_REQ, 32'd12); push(EV_REQLEN, 32'd2);
        push(EV_IR, 32'h0062_2020); push(EV_IRLEN, 32'd1); push(EV_PCW, 32'd1);
        Halt = 1'b0;
        wait_level(0, 1'b1, 20, "req12b");
        Halt = 1'b1;
        wait_drain(20, "fetch12");

        // Timeout: memory never acks, TIMEOUT=4
        mem_en = 1'b0;
        push(EV_REQ, 32'd16); push(EV_REQLEN, 32'd4); push(EV_ERR, 32'd0);
        Halt = 1'b0;
        wait_level(0, 1'b1, 20, "req16");
        Halt = 1'b1;
        wait_drain(20, "timeout");
        Halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("err_sticky", {31'd0, FetchErr}, 32'd1);
            chk("err_no_req", {31'd0, IM_Req}, 32'd0);
            chk("err_no_pcwre", {31'd0, PCWre}, 32'd0);
        end
        Halt = 1'b1;

        // Misaligned address
        Reset = 1'b1; pc_load = 1'b1; pc_val = 32'h0000_0006; mem_en = 1'b1;
        @(negedge CLK);
        chk("reset_clears_err", {31'd0, FetchErr}, 32'd0);
        Reset = 1'b0; pc_load = 1'b0;
        @(negedge CLK);
        push(EV_ERR, 32'd0);
        Halt = 1'b0;
        @(negedge CLK);
        chk("misalign_err", {31'd0, FetchErr}, 32'd1);
        chk("misalign_no_req", {31'd0, IM_Req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("misalign_req_stays_low", {31'd0, IM_Req}, 32'd0);
        end
        wait_drain(5, "misalign");
        Halt = 1'b1; Reset = 1'b1;
        @(negedge CLK);
        chk("reset_clears_misalign_err", {31'd0, FetchErr}, 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the PC register. It samples the PC's Address, issues a request to instruction memory over a req/ack handshake, and captures the returned word into an instruction register (IR) for decode. It then pulses PCWre back to the PC, so the PC advances only after an instruction has been consumed. This makes the single-cycle core tolerant of variable-latency instruction memory.

Parameters:
- ADDR_W, 32, width of Address and IM_Addr.
- DATA_W, 32, instruction word width.
- TIMEOUT, 15, maximum cycles to wait for IM_Ack before declaring a fetch error (≥1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Address  in  ADDR_W  current PC value from the PC register.
- Halt  in  1  stop issuing new fetches; sampled only in IDLE.
- IM_Req  out  1  instruction-memory request.
- IM_Addr  out  ADDR_W  request address; stable while IM_Req=1.
- IM_Ack  in  1  memory response valid; meaningful only while IM_Req=1.
- IM_RData  in  DATA_W  instruction word; valid when IM_Ack=1.
- IR  out  DATA_W  instruction register to decode.
- IR_Valid  out  1  IR holds an undelivered instruction.
- Stall  in  1  decode cannot accept IR this cycle.
- PCWre  out  1  one-cycle PC write enable to the PC register.
- FetchErr  out  1  sticky error flag (misalignment or timeout).

Behaviour:
- Reset (synchronous, active-high; any state, including mid-request) forces the next-cycle values: state IDLE, IM_Req=0, IM_Addr=0, IR=0, IR_Valid=0, PCWre=0, FetchErr=0, timer=0.
- All outputs are registered. States: IDLE, REQ, DELIV, ADV, ERR.
- IDLE:
  - Halt=1: remain in IDLE; all handshake outputs stay 0.
  - Halt=0 and Address[1:0]!=0: go to ERR and set FetchErr=1.
  - Otherwise: IM_Addr<=Address, IM_Req<=1, timer<=0, go to REQ.
  - IM_Ack arriving in IDLE (a late or stale ack) is ignored.
- REQ: IM_Req and IM_Addr are held.
  - IM_Ack=1: IR<=IM_RData, IM_Req<=0, IR_Valid<=1, go to DELIV.
  - No ack: timer++. If timer==TIMEOUT-1, go to ERR, set IM_Req=0 and FetchErr=1.
  - Ack in the same cycle as the timeout: the ack wins.
- DELIV: IR and IR_Valid are held.
  - Stall=1: stay in DELIV.
  - Stall=0: IR_Valid<=0, PCWre<=1, go to ADV. The IR value is retained after delivery.
- ADV: PCWre=1 for exactly this cycle and the PC updates on this edge. Next state is IDLE with PCWre<=0. IDLE therefore always samples the post-update Address.
- ERR: absorbing until Reset. IM_Req=0, IR_Valid=0, PCWre=0, FetchErr=1.
- Halt is ignored outside IDLE: an in-flight fetch completes, delivers, and advances the PC.
- Minimum throughput is 4 cycles per instruction: IDLE, REQ with ack in the first cycle, DELIV with Stall=0, ADV.
- Timer width is $clog2(TIMEOUT+1) and the timer never wraps.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state enum fetch_state_t (IDLE, REQ, DELIV, ADV, ERR);
  - ADDR_W and DATA_W defaults;
  - localparam INSTR_ALIGN_MASK = 2'b11.
- One natural sub-module, fetch_timeout_ctr: clear/enable inputs and an expired output. Everything else stays inline.

Test Plan:
- Zero-latency fetch: Reset for 2 cycles; Address=0, memory acks in the first REQ cycle with 32'h2001_0004, Stall=0.
  - IM_Req=1 with IM_Addr=0.
  - IR=32'h2001_0004 and IR_Valid=1 for one cycle.
  - PCWre=1 for exactly one cycle.
  - Next request uses IM_Addr=4 (the PC model adds 4).
- Latency plus stall: ack 3 cycles after IM_Req; Stall=1 for 2 cycles in DELIV.
  - IM_Req stays high for 4 cycles.
  - IR_Valid stays high for 3 cycles with IR stable.
  - PCWre pulses once, only after Stall drops.
- Timeout: TIMEOUT=4, memory never acks.
  - IM_Req drops after 4 cycles and FetchErr=1.
  - FetchErr stays 1 for 10 further cycles, with no PCWre and no new IM_Req.
- Misaligned: Address=32'h0000_0006 in IDLE.
  - IM_Req never asserts and FetchErr=1 next cycle.
  - Reset clears FetchErr to 0.
- Halt: Halt=1 asserted in REQ.
  - The fetch completes and PCWre pulses once.
  - The unit then stays in IDLE with IM_Req=0 for 8 cycles.
  - Releasing Halt resumes fetching at the new Address.
- Reset mid-request: Reset in the second REQ cycle, then a stray IM_Ack the cycle after reset deasserts.
  - All outputs are 0 after reset.
  - The stray ack is ignored: IR=0 and IR_Valid=0.
  - The following fetch proceeds normally.
